// File: rtl/serial_load_pkg.sv
// serial_load_pkg
// Shared definitions for the serial-to-parallel latch loader.
//   state_t               : controller FSM states
//   SLC_WIDTH_DEFAULT     : default number of data bits per load
//   SLC_EN_CYCLES_DEFAULT : default enable strobe length in clocks
package serial_load_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int SLC_WIDTH_DEFAULT     = 8;
    localparam int SLC_EN_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/serial_load_ctrl.sv
// serial_load_ctrl
// Collects a serial word (MSB first) and presents it to a downstream
// D-latch bank, then pulses the latch enable for EN_CYCLES clocks.
//
// Parameters:
//   WIDTH      : data bits per load
//   EN_CYCLES  : enable strobe length in clocks (1..15)
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   start      : begin a new load (honoured in IDLE only)
//   sdin       : serial data bit, MSB first
//   sdin_valid : qualifies sdin (honoured in SHIFT only)
//   D          : registered parallel word for the latch bank
//   En         : registered latch enable strobe
//   busy       : high whenever the controller is not idle
//   done       : one-clock pulse after the strobe finishes
//   err        : parity error flag (only with SERIAL_LOAD_PARITY_EN)
//
// Build option:
//   SERIAL_LOAD_PARITY_EN : an even-parity bit follows the data bits; a
//   mismatch skips the strobe, pulses done and raises err until the next
//   accepted start.
module serial_load_ctrl
    import serial_load_pkg::*;
#(
    parameter int WIDTH     = SLC_WIDTH_DEFAULT,
    parameter int EN_CYCLES = SLC_EN_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sdin,
    input  logic             sdin_valid,
    output logic [WIDTH-1:0] D,
    output logic             En,
    output logic             busy,
    output logic             done
`ifdef SERIAL_LOAD_PARITY_EN
    ,
    output logic             err
`endif
);

    localparam int               CNT_W       = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       STROBE_LAST = 4'(EN_CYCLES - 1);
`ifdef SERIAL_LOAD_PARITY_EN
    localparam logic [CNT_W-1:0] DATA_DONE   = CNT_W'(WIDTH);
`endif

    state_t           state_q;
    logic [WIDTH-1:0] shiftReg_q;
    logic [WIDTH-1:0] shiftReg_d;
    logic [CNT_W-1:0] bitCnt_q;
    logic [3:0]       strobeCnt_q;
    logic [WIDTH-1:0] data_q;
    logic             en_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_LOAD_PARITY_EN
    logic             err_q;
    logic             parityOk;
`endif

    // The shift register fills from the LSB, so after WIDTH bits the
    // first (most significant) bit has walked up to the top.
    assign shiftReg_d = (shiftReg_q << 1) | WIDTH'(sdin);

`ifdef SERIAL_LOAD_PARITY_EN
    // Even parity: data bits plus the parity bit must XOR to zero.
    assign parityOk = ~(^shiftReg_q ^ sdin);
`endif

    // Single FSM block: every output is a register updated alongside the
    // state, so En rises on the same edge that consumes the final bit and
    // D is only ever written on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shiftReg_q  <= '0;
            bitCnt_q    <= '0;
            strobeCnt_q <= '0;
            data_q      <= '0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SERIAL_LOAD_PARITY_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SHIFT;
                        bitCnt_q <= '0;
                        busy_q   <= 1'b1;
`ifdef SERIAL_LOAD_PARITY_EN
                        err_q    <= 1'b0;
`endif
                    end
                end

                SHIFT: begin
                    if (sdin_valid) begin
`ifdef SERIAL_LOAD_PARITY_EN
                        // Counter parks at WIDTH while the parity bit is
                        // awaited; it never needs to count past that.
                        if (bitCnt_q == DATA_DONE) begin
                            if (parityOk) begin
                                state_q     <= STROBE;
                                data_q      <= shiftReg_q;
                                en_q        <= 1'b1;
                                strobeCnt_q <= '0;
                            end else begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                err_q   <= 1'b1;
                            end
                        end else begin
                            shiftReg_q <= shiftReg_d;
                            bitCnt_q   <= bitCnt_q + 1'b1;
                        end
`else
                        shiftReg_q <= shiftReg_d;
                        bitCnt_q   <= bitCnt_q + 1'b1;
                        if (bitCnt_q == LAST_BIT) begin
                            state_q     <= STROBE;
                            data_q      <= shiftReg_d;
                            en_q        <= 1'b1;
                            strobeCnt_q <= '0;
                        end
`endif
                    end
                end

                STROBE: begin
                    if (strobeCnt_q == STROBE_LAST) begin
                        state_q     <= DONE;
                        en_q        <= 1'b0;
                        done_q      <= 1'b1;
                        strobeCnt_q <= '0;
                    end else begin
                        strobeCnt_q <= strobeCnt_q + 4'd1;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign D    = data_q;
    assign En   = en_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef SERIAL_LOAD_PARITY_EN
    assign err  = err_q;
`endif

endmodule

// File: tb/tb_serial_load_ctrl.sv
// tb_serial_load_ctrl
// Self-checking bench for serial_load_ctrl. One instance with EN_CYCLES=2
// carries the main tests; two more instances (EN_CYCLES=1 and 15) share
// the serial inputs but have their own start so they stay idle otherwise.
// Expected loads are queued when driven and retired on each done pulse.
// Honours SERIAL_LOAD_PARITY_EN when the design is built with it.
module tb_serial_load_ctrl;

    typedef struct {
        logic [7:0] d;
        int         enWidth;
    } expect_t;

    typedef struct {
        logic [7:0] word;
        int         gap;
        bit         junk;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       startAux = 1'b0;
    logic       sdin = 1'b0;
    logic       sdin_valid = 1'b0;
    logic [7:0] D, D1, D15;
    logic       En, busy, done;
    logic       En1, busy1, done1;
    logic       En15, busy15, done15;
`ifdef SERIAL_LOAD_PARITY_EN
    logic       err, err1, err15;
`endif

    expect_t    sbq[$];
    expect_t    popped;
    vec_t       vecs[6];
    logic [7:0] lastExpD = 8'h00;

    int testsRun = 0;
    int testsFailed = 0;
    int enRun = 0;
    int run1 = 0;
    int run15 = 0;
    int width1 = 0;
    int width15 = 0;

    always #5 clk = ~clk;

    serial_load_ctrl #(.WIDTH(8), .EN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .sdin(sdin), .sdin_valid(sdin_valid),
        .D(D), .En(En), .busy(busy), .done(done)
`ifdef SERIAL_LOAD_PARITY_EN
        , .err(err)
`endif
    );

    serial_load_ctrl #(.WIDTH(8), .EN_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(startAux), .sdin(sdin), .sdin_valid(sdin_valid),
        .D(D1), .En(En1), .busy(busy1), .done(done1)
`ifdef SERIAL_LOAD_PARITY_EN
        , .err(err1)
`endif
    );

    serial_load_ctrl #(.WIDTH(8), .EN_CYCLES(15)) dut15 (
        .clk(clk), .rst(rst), .start(startAux), .sdin(sdin), .sdin_valid(sdin_valid),
        .D(D15), .En(En15), .busy(busy15), .done(done15)
`ifdef SERIAL_LOAD_PARITY_EN
        , .err(err15)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Retire one queued load on every done pulse of the main instance,
    // comparing the presented word and how long En stayed high.
    always @(negedge clk) begin
        if (rst) begin
            enRun = 0;
        end else begin
            if (En) enRun++;
            if (done) begin
                if (sbq.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedDone: got done=1, expected no pending load");
                end else begin
                    popped = sbq.pop_front();
                    checkOutput("doneD", D, popped.d);
                    checkOutput("enWidth", enRun, popped.enWidth);
                    checkOutput("busyInDone", busy, 1);
                end
                enRun = 0;
            end
        end
    end

    // Strobe widths of the auxiliary instances, captured on their done.
    always @(negedge clk) begin
        if (rst) begin
            run1  = 0;
            run15 = 0;
        end else begin
            if (En1) run1++;
            if (En15) run15++;
            if (done1) begin
                width1 = run1;
                run1   = 0;
            end
            if (done15) begin
                width15 = run15;
                run15   = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pushExpect(input logic [7:0] d, input int w);
        expect_t e;
        e.d     = d;
        e.enWidth = w;
        sbq.push_back(e);
        lastExpD = d;
    endtask

    task automatic sendBits(input logic [7:0] w, input int gap);
        for (int i = 7; i >= 0; i--) begin
            sdin       = w[i];
            sdin_valid = 1'b1;
            tick();
            sdin_valid = 1'b0;
            if (i > 0) begin
                for (int g = 0; g < gap; g++) tick();
            end
        end
    endtask

`ifdef SERIAL_LOAD_PARITY_EN
    task automatic sendParity(input logic [7:0] w, input bit flip);
        sdin       = (^w) ^ flip;
        sdin_valid = 1'b1;
        tick();
        sdin_valid = 1'b0;
    endtask
`endif

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: got no done within 300 cycles, expected done pulse", name);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        pushExpect(v.word, 2);
        pulseStart();
        sendBits(v.word, v.gap);
`ifdef SERIAL_LOAD_PARITY_EN
        sendParity(v.word, 1'b0);
`endif
        checkOutput("latencyEn", En, 1);
        if (v.junk) begin
            sdin       = 1'b1;
            sdin_valid = 1'b1;
        end
        waitDone("vecDone");
        @(negedge clk);
        sdin_valid = 1'b0;
        checkOutput("busyAfter", busy, 0);
        checkOutput("doneAfter", done, 0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no finish, expected bench to complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0].word = 8'hA5; vecs[0].gap = 0; vecs[0].junk = 1'b0;
        vecs[1].word = 8'hA5; vecs[1].gap = 3; vecs[1].junk = 1'b0;
        vecs[2].word = 8'h3C; vecs[2].gap = 0; vecs[2].junk = 1'b1;
        vecs[3].word = 8'hFF; vecs[3].gap = 1; vecs[3].junk = 1'b0;
        vecs[4].word = 8'h00; vecs[4].gap = 0; vecs[4].junk = 1'b0;
        vecs[5].word = 8'h81; vecs[5].gap = 2; vecs[5].junk = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        checkOutput("resetD", D, 0);
        checkOutput("resetEn", En, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        rst = 1'b0;
        tick();

        // Table-driven loads, with and without valid gaps and junk bits
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Reset in the middle of SHIFT: no strobe, then a clean load
        pulseStart();
        for (int i = 0; i < 4; i++) begin
            sdin       = 1'b1;
            sdin_valid = 1'b1;
            tick();
        end
        sdin_valid = 1'b0;
        checkOutput("abortNoEn", En, 0);
        checkOutput("abortBusy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abortD", D, 0);
        checkOutput("abortBusyCleared", busy, 0);
        begin
            vec_t v;
            v.word = 8'h3C; v.gap = 0; v.junk = 1'b0;
            applyStimulus(v);
        end

        // Reset in the middle of STROBE: En drops, no done pulse
        pulseStart();
        sendBits(8'hA5, 0);
`ifdef SERIAL_LOAD_PARITY_EN
        sendParity(8'hA5, 1'b0);
`endif
        checkOutput("midStrobeEn", En, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("strobeResetEn", En, 0);
        checkOutput("strobeResetDone", done, 0);
        checkOutput("strobeResetBusy", busy, 0);
        checkOutput("strobeResetD", D, 0);
        repeat (4) tick();
        checkOutput("noLateDone", done, 0);

        // start held high across two loads
        pushExpect(8'hA5, 2);
        pushExpect(8'h3C, 2);
        start = 1'b1;
        tick();
        sendBits(8'hA5, 0);
`ifdef SERIAL_LOAD_PARITY_EN
        sendParity(8'hA5, 1'b0);
`endif
        checkOutput("heldLatency1", En, 1);
        waitDone("heldDone1");
        @(negedge clk);
        checkOutput("heldIdleBusy", busy, 0);
        checkOutput("heldIdleDone", done, 0);
        @(negedge clk);
        checkOutput("heldRestartBusy", busy, 1);
        sendBits(8'h3C, 0);
`ifdef SERIAL_LOAD_PARITY_EN
        sendParity(8'h3C, 1'b0);
`endif
        checkOutput("heldLatency2", En, 1);
        start = 1'b0;
        waitDone("heldDone2");
        @(negedge clk);
        @(negedge clk);
        checkOutput("heldFinalBusy", busy, 0);

        // Strobe widths at the EN_CYCLES extremes
        startAux = 1'b1;
        tick();
        startAux = 1'b0;
        sendBits(8'h5A, 0);
`ifdef SERIAL_LOAD_PARITY_EN
        sendParity(8'h5A, 1'b0);
`endif
        checkOutput("aux1Latency", En1, 1);
        checkOutput("aux15Latency", En15, 1);
        begin
            int n;
            n = 0;
            while (done15 !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            checkOutput("aux15DoneSeen", done15, 1);
        end
        @(negedge clk);
        checkOutput("width1", width1, 1);
        checkOutput("width15", width15, 15);
        checkOutput("aux1D", D1, 8'h5A);
        checkOutput("aux15D", D15, 8'h5A);
        checkOutput("mainUntouched", busy, 0);

`ifdef SERIAL_LOAD_PARITY_EN
        // Good parity clears nothing; bad parity skips the strobe
        checkOutput("errClearAfterGood", err, 0);
        pushExpect(lastExpD, 0);
        pulseStart();
        sendBits(8'hA5, 0);
        sendParity(8'hA5, 1'b1);
        checkOutput("parityNoEn", En, 0);
        waitDone("parityDone");
        checkOutput("parityErrInDone", err, 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("parityErrHeld", err, 1);
        checkOutput("parityBusy", busy, 0);
        pulseStart();
        checkOutput("parityErrCleared", err, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        checkOutput("scoreboardEmpty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/serial_load_ctrl.md
SERIAL_LOAD_CTRL -- requirements
Module: serial_load_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits assembled and presented to the downstream D-latch bank.
REQ-002 Parameter EN_CYCLES, default 2, range 1..15, length in clocks of the enable strobe.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a new load; sampled only in IDLE.
REQ-006 sdin  input  1  serial data bit, MSB first.
REQ-007 sdin_valid  input  1  qualifies sdin; a bit is consumed only on a cycle with sdin_valid=1 in SHIFT.
REQ-008 D  output  WIDTH  parallel data to the latch bank; registered.
REQ-009 En  output  1  latch enable strobe; registered.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-clock pulse on the cycle after En deasserts.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, STROBE and DONE.
REQ-013 IDLE -> SHIFT when start=1; the bit counter SHALL clear to 0 on that transition.
REQ-014 In SHIFT, each sdin_valid=1 cycle SHALL shift sdin into the LSB of the shift register and increment the bit counter; cycles with sdin_valid=0 SHALL hold all state.
REQ-015 SHIFT -> STROBE on the cycle the WIDTH-th bit is consumed; D SHALL load the complete word on that same edge.
REQ-016 En SHALL be high for exactly EN_CYCLES consecutive clocks starting on the first STROBE cycle; D SHALL stay stable for the whole strobe and afterwards until the next STROBE entry.
REQ-017 STROBE -> DONE after EN_CYCLES clocks; DONE -> IDLE unconditionally after one clock, with done=1 only in DONE.
REQ-018 start SHALL be ignored outside IDLE; sdin_valid SHALL be ignored outside SHIFT.
REQ-019 Latency: the first En=1 cycle SHALL be exactly one clock after the edge that consumes the last bit.
REQ-020 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap; the strobe counter SHALL be 4 bits.
REQ-021 start asserted in the DONE cycle SHALL be ignored; a new load requires start in IDLE.

Reset
REQ-022 On rst=1 at a clock edge: state=IDLE, D=0, En=0, busy=0, done=0, counters=0, shift register=0.
REQ-023 rst SHALL take priority over all other inputs, including mid-SHIFT and mid-STROBE; an interrupted strobe SHALL drop En on the reset edge with no done pulse.

Configuration
REQ-024 Macro SERIAL_LOAD_PARITY_EN: when defined, SHIFT SHALL consume one extra even-parity bit after the WIDTH data bits, and an added output err (1 bit, reset 0) SHALL exist.
REQ-025 With SERIAL_LOAD_PARITY_EN, a parity mismatch SHALL skip STROBE (En stays 0, D unchanged), go directly to DONE with done=1, and set err=1 until the next start is accepted.
REQ-026 Without SERIAL_LOAD_PARITY_EN, no err port and no parity bit SHALL exist; behaviour is as in REQ-012..REQ-021.

Structure
REQ-027 Package serial_load_pkg SHALL hold the state enum type and the default constants for WIDTH and EN_CYCLES.
REQ-028 No sub-module SHALL be used; the shift register, counters and FSM SHALL reside in serial_load_ctrl.

Verification
REQ-029 WIDTH=8, EN_CYCLES=2: start, then bits 1,0,1,0,0,1,0,1 on consecutive valid cycles -> D=8'hA5, En high for exactly 2 clocks, done pulse on the next clock, busy low afterwards.
REQ-030 Same word with sdin_valid=0 gaps of 3 cycles between bits -> identical D=8'hA5 and En timing relative to the last valid bit.
REQ-031 rst pulsed after 4 bits, then a full load of 8'h3C -> no En during the aborted load; D=8'h3C after the second load.
REQ-032 start held high continuously through two loads -> second load begins only from IDLE, one cycle after done; start pulses during SHIFT/STROBE have no effect.
REQ-033 EN_CYCLES=1 and EN_CYCLES=15 -> En width of exactly 1 and 15 clocks.
REQ-034 With SERIAL_LOAD_PARITY_EN: 8'hA5 + parity 0 -> normal strobe, err=0; 8'hA5 + parity 1 -> En never asserts, done pulses, err=1 until the next start.
